// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter: FSM states and parity codes.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO queueing host bytes ahead of the transmitter. Push is ignored
// when full and pop is ignored when empty; the head word is read combinationally.
module uart_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          push,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          pop,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     cnt;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt == LW'(FIFO_DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];
  assign level   = cnt;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: run-time baud divisor, 5..DATA_W data bits,
// none/even/odd parity, 1 or 2 stop bits, fed from a small input FIFO.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [DATA_W-1:0]           i_dat,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [DIV_W-1:0]            i_div,
  input  logic [3:0]                  i_nbits,
  input  logic [1:0]                  i_parity,
  input  logic                        i_stop2,
  output logic [$clog2(FIFO_DEPTH):0] o_level,
  output logic                        o_busy,
  output logic                        o_tx
);

  localparam int BW = $clog2(DATA_W);

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q;
  logic [DIV_W-1:0]  div_q;
  logic [BW-1:0]     bit_q;
  logic [BW-1:0]     last_q;
  logic [DATA_W-1:0] shift_q;
  logic              par_en_q;
  logic              par_bit_q;
  logic              stop2_q;
  logic              tx_q, tx_d;
  logic              pop;
  logic              tick;
  logic              shift_en;
  logic [DATA_W-1:0] head;
  logic              full;
  logic              empty;

  // Index of the last data bit after clamping the requested width to 5..DATA_W.
  function automatic logic [BW-1:0] clamp_last(input logic [3:0] n);
    int v;
    v = int'(n);
    if (v < 5)      v = 5;
    if (v > DATA_W) v = DATA_W;
    return BW'(v - 1);
  endfunction

  // Parity over the active data bits only; bits above the frame width are ignored.
  function automatic logic frame_parity(input logic [DATA_W-1:0] d,
                                        input logic [BW-1:0]     last,
                                        input logic [1:0]        par);
    logic p;
    p = (par == PAR_ODD);
    for (int i = 0; i < DATA_W; i++) begin
      if (i <= int'(last)) p = p ^ d[i];
    end
    return p;
  endfunction

  uart_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .push    (i_valid),
    .wr_data (i_dat),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (o_level)
  );

  assign o_ready = ~full;
  assign o_busy  = (state_q != ST_IDLE) | (o_level != '0);
  assign o_tx    = tx_q;
  assign tick    = (state_q != ST_IDLE) && (cnt_q == div_q);

  // Control state: FSM, baud counter, bit counter and the registered line driver.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      if (state_q == ST_IDLE || pop || tick) cnt_q <= '0;
      else                                   cnt_q <= cnt_q + 1'b1;
      if (pop)           bit_q <= '0;
      else if (shift_en) bit_q <= bit_q + 1'b1;
    end
  end

  // Frame registers: captured at pop so config changes mid-frame are invisible.
  always_ff @(posedge i_clk) begin
    if (pop) begin
      shift_q   <= head;
      div_q     <= i_div;
      last_q    <= clamp_last(i_nbits);
      par_en_q  <= (i_parity == PAR_EVEN) || (i_parity == PAR_ODD);
      par_bit_q <= frame_parity(head, clamp_last(i_nbits), i_parity);
      stop2_q   <= i_stop2;
    end else if (shift_en) begin
      shift_q   <= shift_q >> 1;
    end
  end

  // Next-state and next line level; every frame boundary either pops or idles.
  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    pop      = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          state_d = ST_START;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_q == last_q) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP1;
            tx_d    = par_en_q ? par_bit_q : 1'b1;
          end else begin
            shift_en = 1'b1;
            tx_d     = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP1;
          tx_d    = 1'b1;
        end
      end
      ST_STOP1, ST_STOP2: begin
        if (tick) begin
          if (state_q == ST_STOP1 && stop2_q) begin
            state_d = ST_STOP2;
            tx_d    = 1'b1;
          end else if (!empty) begin
            pop     = 1'b1;
            state_d = ST_START;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: the driver queues the expected line waveform
// of every accepted byte; a monitor pops and checks each frame as it appears.
module tb_uart_tx_cfg;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV_W      = 16;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b1;
  logic [DATA_W-1:0] i_dat = '0;
  logic              i_valid = 1'b0;
  logic              o_ready;
  logic [DIV_W-1:0]  i_div = '0;
  logic [3:0]        i_nbits = 4'd8;
  logic [1:0]        i_parity = 2'b00;
  logic              i_stop2 = 1'b0;
  logic [$clog2(FIFO_DEPTH):0] o_level;
  logic              o_busy;
  logic              o_tx;

  uart_tx_cfg #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DIV_W      (DIV_W)
  ) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_dat    (i_dat),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_div    (i_div),
    .i_nbits  (i_nbits),
    .i_parity (i_parity),
    .i_stop2  (i_stop2),
    .o_level  (o_level),
    .o_busy   (o_busy),
    .o_tx     (o_tx)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] bits;
    int          len;
    int          div;
    int          pcyc;
  } frame_t;

  frame_t exp_q[$];
  int     vectors  = 0;
  int     errors   = 0;
  int     last_end = -100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference frame: start 0, n data bits LSB first, optional parity, 1 or 2 stop 1s.
  function automatic frame_t build(input logic [7:0] d, input int div, input int nbits,
                                   input int par, input int stop2, input int pcyc);
    frame_t f;
    int     n;
    int     idx;
    logic   x;
    n = (nbits < 5) ? 5 : ((nbits > DATA_W) ? DATA_W : nbits);
    f.bits = '0;
    idx = 0;
    f.bits[idx] = 1'b0; idx++;
    x = 1'b0;
    for (int i = 0; i < n; i++) begin
      f.bits[idx] = d[i]; idx++;
      x = x ^ d[i];
    end
    if (par == 1) begin f.bits[idx] = x;  idx++; end
    if (par == 2) begin f.bits[idx] = ~x; idx++; end
    f.bits[idx] = 1'b1; idx++;
    if (stop2 != 0) begin f.bits[idx] = 1'b1; idx++; end
    f.len  = idx;
    f.div  = div;
    f.pcyc = pcyc;
    return f;
  endfunction

  task automatic set_cfg(input int d, input int n, input int p, input int s);
    @(negedge i_clk);
    i_div    = DIV_W'(d);
    i_nbits  = 4'(n);
    i_parity = 2'(p);
    i_stop2  = 1'(s);
  endtask

  // One push attempt in the next cycle; accepted when the FIFO reports ready.
  task automatic push(input logic [7:0] d, output bit acc);
    @(negedge i_clk);
    acc     = o_ready;
    i_dat   = d;
    i_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    if (acc)
      exp_q.push_back(build(d, int'(i_div), int'(i_nbits), int'(i_parity), int'(i_stop2), cyc));
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge i_clk);
      if (!o_busy && exp_q.size() == 0) break;
    end
    if (k == 3000) begin
      vectors++;
      errors++;
      $display("FAIL idle_timeout: busy=%0b pending=%0d, expected idle", o_busy, exp_q.size());
    end else begin
      chk("busy_drop_cycle", cyc, last_end + 1);
      chk("idle_line", o_tx, 1'b1);
    end
  endtask

  // Monitor: each falling line edge is a frame start; check timing and every bit.
  frame_t e;
  logic [15:0] act_bits;
  bit          aborted;
  initial begin
    forever begin
      @(negedge i_clk);
      if (!i_reset && o_tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_start at cycle %0d: got start bit, expected idle line", cyc);
          for (int k = 0; k < 64 && o_tx !== 1'b1; k++) @(negedge i_clk);
        end else begin
          e = exp_q.pop_front();
          chk("start_cycle", cyc, ((last_end > e.pcyc) ? last_end : e.pcyc) + 1);
          act_bits = e.bits;
          aborted  = 1'b0;
          for (int b = 0; b < e.len && !aborted; b++) begin
            for (int c = 0; c <= e.div && !aborted; c++) begin
              if (b != 0 || c != 0) @(negedge i_clk);
              if (i_reset)                aborted = 1'b1;
              else if (o_tx !== e.bits[b]) act_bits[b] = o_tx;
            end
          end
          if (aborted) last_end = -100;
          else begin
            chk("frame_bits", act_bits, e.bits);
            last_end = cyc;
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bit acc;
  int nacc;
  bit acc6;
  initial begin
    repeat (3) @(negedge i_clk);
    chk("rst_tx", o_tx, 1'b1);
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_level", o_level, 0);
    i_reset = 1'b0;

    // 8N1, div 3, 0x55
    set_cfg(3, 8, 0, 0);
    push(8'h55, acc);
    chk("pre_start_line", o_tx, 1'b1);
    wait_idle();

    // 7E2 then 7O1 with 0x03
    set_cfg(1, 7, 1, 1);
    push(8'h03, acc);
    wait_idle();
    set_cfg(1, 7, 2, 0);
    push(8'h03, acc);
    wait_idle();

    // Width clamping
    set_cfg(0, 5, 0, 0);
    push(8'hFF, acc);
    wait_idle();
    set_cfg(0, 2, 0, 0);
    push(8'hFF, acc);
    wait_idle();
    set_cfg(0, 15, 1, 0);
    push(8'hA7, acc);
    wait_idle();

    // Six back-to-back pushes into a 4-deep FIFO: fifth fills it, sixth is dropped
    set_cfg(0, 8, 0, 0);
    nacc = 0;
    for (int i = 0; i < 5; i++) begin
      push(8'(8'h11 * (i + 1)), acc);
      if (acc) nacc++;
    end
    chk("level_full", o_level, FIFO_DEPTH);
    chk("ready_full", o_ready, 1'b0);
    push(8'h66, acc6);
    if (acc6) nacc++;
    chk("accepted_count", nacc, 5);
    wait_idle();

    // Reset in the middle of a data bit
    set_cfg(2, 8, 0, 0);
    push(8'hC3, acc);
    repeat (6) @(posedge i_clk);
    #2;
    i_reset = 1'b1;
    #1;
    chk("midrst_tx", o_tx, 1'b1);
    chk("midrst_level", o_level, 0);
    chk("midrst_ready", o_ready, 1'b1);
    chk("midrst_busy", o_busy, 1'b0);
    exp_q.delete();
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    push(8'h5A, acc);
    wait_idle();

    // Config change while a frame is on the line
    set_cfg(2, 8, 0, 0);
    push(8'hA5, acc);
    repeat (3) @(posedge i_clk);
    set_cfg(1, 6, 2, 1);
    push(8'h3C, acc);
    wait_idle();

    // Randomized groups with stable config per group
    for (int g = 0; g < 15; g++) begin
      set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(3, 10)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
      for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
        push(8'($urandom), acc);
      end
      wait_idle();
    end

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
